cpu_boot_ctrl: RTL and testbench
================================

// Module: cpu_boot_ctrl
// PURPOSE
//  Sequences the pipelined RISC-V core for a program run.
//  - Holds the core in reset.
//  - Streams a program image from a valid/ready source into instruction memory.
//  - Releases the core after a fixed reset hold.
//  - Monitors the PC for halt (self-loop) or timeout.
//  - Reports halted PC and cycle count.
// PARAMETERS
//  ADDR_W      10     imem word-address width; depth = 2**ADDR_W words
//  RST_HOLD    4      cycles core_rst_n stays low after load, before release (>=1)
//  STALL_LIMIT 8      consecutive cycles with unchanged core_pc that declare halt (>=2)
//  MAX_CYCLES  100000 run-cycle budget before timeout
// PORTS
//  clock       in   1       system clock, all state on posedge
//  reset_n     in   1       async active-low reset
//  start       in   1       1-cycle pulse: begin load+run (honoured in IDLE/DONE only)
//  load_len    in   ADDR_W+1 words to load, sampled with start
//  ld_valid    in   1       source word valid
//  ld_data     in   32      source instruction word
//  ld_ready    out  1       controller accepts word
//  imem_we     out  1       imem write strobe
//  imem_addr   out  ADDR_W  imem word address
//  imem_wdata  out  32      imem write data
//  core_pc     in   32      core fetch PC
//  core_rst_n  out  1       core reset, active-low, registered
//  busy        out  1       state is LOAD, HOLD or RUN
//  done        out  1       run finished (state DONE)
//  timeout     out  1       DONE reached via MAX_CYCLES (sticky until next start)
//  halted_pc   out  32      core_pc captured on halt/timeout
//  cycle_cnt   out  32      cycles spent in RUN
// BEHAVIOUR
//  - Reset (async, reset_n=0):
//    - state=IDLE.
//    - All outputs 0, including core_rst_n (core held in reset).
//    - All counters 0.
//  - FSM IDLE -> LOAD -> HOLD -> RUN -> DONE; DONE -> LOAD/HOLD on start.
//  - IDLE/DONE, start=1:
//    - len = min(load_len, 2**ADDR_W); word counter wc=0.
//    - Clear cycle_cnt, timeout, done and halted_pc.
//    - Next state = LOAD if len!=0, else HOLD.
//    - start in LOAD/HOLD/RUN is ignored.
//  - LOAD:
//    - ld_ready=1 (registered, high from the first LOAD cycle).
//    - imem_we = ld_valid & ld_ready; imem_addr = wc; imem_wdata = ld_data. These are combinational, zero latency.
//    - Each accepted word increments wc.
//    - On acceptance with wc==len-1: next state HOLD; ld_ready=0 on the following cycle.
//    - Outside LOAD: imem_we=0, ld_ready=0.
//  - HOLD:
//    - core_rst_n=0 for exactly RST_HOLD cycles, then state RUN.
//    - core_rst_n=1 from the first RUN cycle.
//  - RUN:
//    - cycle_cnt increments every RUN cycle, saturating at 2**32-1.
//    - same_cnt:
//      - Increments when core_pc == core_pc of the previous cycle.
//      - Resets to 0 on any change.
//      - The first RUN cycle counts as a change.
//    - Halt: same_cnt reaches STALL_LIMIT-1, i.e. PC held for STALL_LIMIT cycles.
//      - Next state DONE; halted_pc = core_pc.
//    - Timeout: cycle_cnt reaches MAX_CYCLES.
//      - Next state DONE; timeout=1; halted_pc = core_pc.
//    - Halt and timeout in the same cycle: halt wins, timeout=0.
//  - DONE:
//    - done=1; core_rst_n=0 (core frozen).
//    - halted_pc, cycle_cnt and timeout held until the next start.
//  - Async reset mid-LOAD/RUN aborts immediately. Partial imem contents are not cleared.
// TESTING
//  - Reset: reset_n low mid-RUN -> next sample core_rst_n=0, busy=0, ld_ready=0, done=0.
//  - Load 4 words (0x00000013 x3, 0x0000006F), ld_valid gapped every other cycle:
//    - imem writes exactly addr 0..3 with the matching data.
//    - ld_ready drops one cycle after the 4th accept.
//  - Release and halt, program ending in jal x0,0 at PC 0xC, STALL_LIMIT=8:
//    - core_rst_n=0 for exactly 4 cycles after LOAD.
//    - done=1 after PC is stable for 8 cycles.
//    - halted_pc=0x0000000C; timeout=0.
//  - Timeout: MAX_CYCLES=50 with PC incrementing every cycle -> done=1, timeout=1, cycle_cnt=50.
//  - Edges:
//    - load_len=0 -> HOLD directly, no imem_we.
//    - load_len=2**ADDR_W+5 -> exactly 2**ADDR_W writes.
//    - start during RUN -> ignored.
//  - Restart: start in DONE -> cycle_cnt, timeout and done cleared; a second run completes normally.

Source files
------------

// File: rtl/cpu_boot_ctrl.sv
// Boot sequencer: loads a program image into imem, releases the core from reset,
// then watches its PC for a self-loop halt or a run-cycle timeout.
module cpu_boot_ctrl #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned RST_HOLD    = 4,
    parameter int unsigned STALL_LIMIT = 8,
    parameter int unsigned MAX_CYCLES  = 100000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       core_pc,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       halted_pc,
    output logic [31:0]       cycle_cnt
);

    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
    localparam int unsigned SAME_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    wc_q, wc_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [SAME_W-1:0]   same_q, same_d;
    logic [31:0]         prev_pc_q, prev_pc_d;
    logic                run_first_q, run_first_d;
    logic [31:0]         cycle_cnt_q, cycle_cnt_d;
    logic                timeout_q, timeout_d;
    logic [31:0]         halted_pc_q, halted_pc_d;
    logic                ld_ready_q, ld_ready_d;
    logic                core_rst_n_q, core_rst_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept;
    logic [LEN_W-1:0]    len_c;
    logic [31:0]         cycle_inc;
    logic [SAME_W-1:0]   same_inc;

    // Next-state, counter updates and the zero-latency imem write path.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        wc_d         = wc_q;
        hold_d       = hold_q;
        same_d       = same_q;
        prev_pc_d    = prev_pc_q;
        run_first_d  = run_first_q;
        cycle_cnt_d  = cycle_cnt_q;
        timeout_d    = timeout_q;
        halted_pc_d  = halted_pc_q;

        accept       = ld_valid & ld_ready_q;
        imem_we      = accept;
        imem_addr    = wc_q[ADDR_W-1:0];
        imem_wdata   = ld_data;

        len_c        = (load_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : load_len;
        cycle_inc    = (cycle_cnt_q == 32'hFFFF_FFFF) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
        // The first RUN cycle always counts as a PC change.
        same_inc     = (run_first_q || (core_pc != prev_pc_q)) ? SAME_W'(0) : same_q + SAME_W'(1);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d       = len_c;
                    wc_d        = LEN_W'(0);
                    hold_d      = HOLD_W'(0);
                    cycle_cnt_d = 32'd0;
                    timeout_d   = 1'b0;
                    halted_pc_d = 32'd0;
                    state_d     = (len_c == LEN_W'(0)) ? S_HOLD : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wc_d = wc_q + LEN_W'(1);
                    if (wc_q == len_q - LEN_W'(1)) begin
                        state_d = S_HOLD;
                        hold_d  = HOLD_W'(0);
                    end
                end
            end
            S_HOLD: begin
                hold_d = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
                    state_d     = S_RUN;
                    run_first_d = 1'b1;
                    same_d      = SAME_W'(0);
                end
            end
            S_RUN: begin
                run_first_d = 1'b0;
                prev_pc_d   = core_pc;
                same_d      = same_inc;
                cycle_cnt_d = cycle_inc;
                // Halt takes priority over a coincident timeout.
                if (same_inc == SAME_W'(STALL_LIMIT - 1)) begin
                    state_d     = S_DONE;
                    halted_pc_d = core_pc;
                end else if (cycle_inc == 32'(MAX_CYCLES)) begin
                    state_d     = S_DONE;
                    timeout_d   = 1'b1;
                    halted_pc_d = core_pc;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ld_ready_d   = (state_d == S_LOAD);
        core_rst_n_d = (state_d == S_RUN);
        busy_d       = (state_d == S_LOAD) || (state_d == S_HOLD) || (state_d == S_RUN);
        done_d       = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            wc_q         <= '0;
            hold_q       <= '0;
            same_q       <= '0;
            prev_pc_q    <= '0;
            run_first_q  <= 1'b0;
            cycle_cnt_q  <= '0;
            timeout_q    <= 1'b0;
            halted_pc_q  <= '0;
            ld_ready_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            wc_q         <= wc_d;
            hold_q       <= hold_d;
            same_q       <= same_d;
            prev_pc_q    <= prev_pc_d;
            run_first_q  <= run_first_d;
            cycle_cnt_q  <= cycle_cnt_d;
            timeout_q    <= timeout_d;
            halted_pc_q  <= halted_pc_d;
            ld_ready_q   <= ld_ready_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign ld_ready   = ld_ready_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign halted_pc  = halted_pc_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Scoreboard bench for cpu_boot_ctrl: expected imem writes and run results are
// queued at stimulus time and checked by an independent monitor.
module tb_cpu_boot_ctrl;

    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned RST_HOLD    = 4;
    localparam int unsigned STALL_LIMIT = 8;
    localparam int unsigned MAX_CYCLES  = 50;
    localparam int unsigned DEPTH       = 1 << ADDR_W;

    logic              clock;
    logic              reset_n;
    logic              start;
    logic [ADDR_W:0]   load_len;
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [31:0]       core_pc;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [31:0]       halted_pc;
    logic [31:0]       cycle_cnt;

    cpu_boot_ctrl #(
        .ADDR_W      (ADDR_W),
        .RST_HOLD    (RST_HOLD),
        .STALL_LIMIT (STALL_LIMIT),
        .MAX_CYCLES  (MAX_CYCLES)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .load_len   (load_len),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_pc    (core_pc),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .halted_pc  (halted_pc),
        .cycle_cnt  (cycle_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct packed {
        logic        to;
        logic [31:0] pc;
        logic [31:0] cnt;
    } res_t;

    wr_t         exp_wr[$];
    res_t        exp_res[$];

    int          checks = 0;
    int          errors = 0;

    logic [31:0] src [0:DEPTH+7];
    int          src_len = 0;
    int          src_idx = 0;
    bit          gapped  = 1'b0;
    bit          tgl     = 1'b0;
    bit          drv_acc = 1'b0;

    int          pc_mode = 0;
    logic [31:0] rpc [0:MAX_CYCLES+7];
    int          k = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // PC the simulated core presents on its kk-th cycle out of reset.
    function automatic logic [31:0] pc_fn(input int kk);
        case (pc_mode)
            0:       return (kk < 3) ? 32'(4 * kk) : 32'h0000_000C;
            1:       return 32'(4 * kk);
            default: return (kk < int'(MAX_CYCLES) + 8) ? rpc[kk] : 32'h0;
        endcase
    endfunction

    // Reference: first cycle whose PC matches the previous STALL_LIMIT-1 PCs
    // of this run halts; otherwise the MAX_CYCLES-th run cycle times out.
    function automatic res_t model();
        logic [31:0] p[$];
        res_t        r;
        bit          same;
        r = '0;
        for (int i = 0; i < int'(MAX_CYCLES); i++) begin
            p.push_back(pc_fn(i));
            if (i >= int'(STALL_LIMIT) - 1) begin
                same = 1'b1;
                for (int j = 1; j < int'(STALL_LIMIT); j++)
                    if (p[i-j] != p[i]) same = 1'b0;
                if (same) begin
                    r.to = 1'b0; r.pc = p[i]; r.cnt = 32'(i + 1);
                    return r;
                end
            end
            if (i + 1 == int'(MAX_CYCLES)) begin
                r.to = 1'b1; r.pc = p[i]; r.cnt = 32'(i + 1);
                return r;
            end
        end
        return r;
    endfunction

    // Source and core driver: advances on accepted words, presents PC sequence.
    always begin
        @(negedge clock);
        drv_acc = ld_valid && ld_ready;
        @(posedge clock);
        #1;
        if (drv_acc) src_idx++;
        tgl = !tgl;
        if (src_idx < src_len && (!gapped || tgl)) begin
            ld_valid = 1'b1;
            ld_data  = src[src_idx];
        end else begin
            ld_valid = 1'b0;
            ld_data  = 32'h0;
        end
        if (core_rst_n) begin
            core_pc = pc_fn(k);
            k++;
        end else begin
            k = 0;
            core_pc = 32'h0;
        end
    end

    int          hold_cnt  = 0;
    bit          prev_done = 1'b0;
    bit          prev_rst  = 1'b0;
    bit          last_pend = 1'b0;

    // Monitor: imem writes, ld_ready drop, reset-hold length, run results.
    always @(negedge clock) begin
        if (!reset_n) begin
            hold_cnt  = 0;
            prev_done = 1'b0;
            prev_rst  = 1'b0;
            last_pend = 1'b0;
        end else begin
            wr_t  w;
            res_t r;
            if (last_pend) begin
                chk("ld_ready_drop", 32'(ld_ready), 32'd0);
                last_pend = 1'b0;
            end
            if (imem_we) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%08h with no write expected", imem_addr, imem_wdata);
                end else begin
                    w = exp_wr.pop_front();
                    chk("imem_addr", 32'(imem_addr), 32'(w.addr));
                    chk("imem_wdata", imem_wdata, w.data);
                    if (exp_wr.size() == 0) last_pend = 1'b1;
                end
            end
            if (busy && !ld_ready && !core_rst_n) begin
                hold_cnt++;
            end else if (core_rst_n && !prev_rst) begin
                chk("hold_len", 32'(hold_cnt), 32'(RST_HOLD));
                hold_cnt = 0;
            end else if (!busy) begin
                hold_cnt = 0;
            end
            if (done && !prev_done) begin
                if (exp_res.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: pc 0x%08h cnt %0d with no run expected", halted_pc, cycle_cnt);
                end else begin
                    r = exp_res.pop_front();
                    chk("timeout", 32'(timeout), 32'(r.to));
                    chk("halted_pc", halted_pc, r.pc);
                    chk("cycle_cnt", cycle_cnt, r.cnt);
                    chk("done_core_rst_n", 32'(core_rst_n), 32'd0);
                    chk("done_busy", 32'(busy), 32'd0);
                end
            end
            prev_done = done;
            prev_rst  = core_rst_n;
        end
    end

    task automatic begin_run(input int len, input bit gap, input int mode, input bit fixed_prog);
        int n;
        pc_mode = mode;
        if (mode == 2) begin
            rpc[0] = 32'(4 * $urandom_range(0, 3));
            for (int i = 1; i < int'(MAX_CYCLES) + 8; i++)
                rpc[i] = ($urandom_range(0, 3) != 0) ? rpc[i-1] : 32'(4 * $urandom_range(0, 15));
        end
        for (int i = 0; i < len; i++)
            src[i] = fixed_prog ? ((i == 3) ? 32'h0000_006F : 32'h0000_0013) : $urandom;
        n = (len > int'(DEPTH)) ? int'(DEPTH) : len;
        for (int i = 0; i < n; i++) exp_wr.push_back({ADDR_W'(i), src[i]});
        exp_res.push_back(model());
        @(posedge clock);
        #1;
        gapped   = gap;
        src_len  = len;
        src_idx  = 0;
        load_len = (ADDR_W + 1)'(len);
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("start_clr_done", 32'(done), 32'd0);
        chk("start_clr_timeout", 32'(timeout), 32'd0);
        chk("start_clr_cycle_cnt", cycle_cnt, 32'd0);
        chk("start_clr_halted_pc", halted_pc, 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_core_run();
        int n = 0;
        while (!core_rst_n && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (!core_rst_n) begin
            checks++;
            errors++;
            $display("FAIL release_wait: core_rst_n still 0 after %0d cycles", n);
        end
    endtask

    task automatic finish_run();
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_wait: done still 0 after %0d cycles", n);
        end
        @(posedge clock);
        #1;
        chk("writes_pending", 32'(exp_wr.size()), 32'd0);
        chk("results_pending", 32'(exp_res.size()), 32'd0);
        exp_wr.delete();
        exp_res.delete();
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        load_len = '0;
        ld_valid = 1'b0;
        ld_data  = 32'h0;
        core_pc  = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_halted_pc", halted_pc, 32'd0);
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        reset_n = 1'b1;

        // Four-word program ending in a self-loop at 0xC, gapped source.
        begin_run(4, 1'b1, 0, 1'b1);
        finish_run();

        // PC keeps moving: timeout after MAX_CYCLES run cycles; restart from DONE.
        begin_run(2, 1'b0, 1, 1'b0);
        finish_run();

        // Zero-length load goes straight to reset hold.
        begin_run(0, 1'b0, 0, 1'b0);
        finish_run();

        // Oversized load is clipped to the imem depth.
        begin_run(int'(DEPTH) + 5, 1'b0, 2, 1'b0);
        finish_run();

        // start during RUN is ignored.
        begin_run(0, 1'b0, 0, 1'b0);
        wait_core_run();
        repeat (2) @(posedge clock);
        #1;
        src_len  = 3;
        src_idx  = 0;
        load_len = (ADDR_W + 1)'(3);
        start    = 1'b1;
        @(posedge clock);
        #1;
        start   = 1'b0;
        src_len = 0;
        chk("ignored_start_busy", 32'(busy), 32'd1);
        chk("ignored_start_core", 32'(core_rst_n), 32'd1);
        finish_run();

        // Randomized runs.
        for (int t = 0; t < 10; t++) begin
            begin_run(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), 1'b0);
            finish_run();
        end

        // Asynchronous reset in the middle of a run.
        begin_run(2, 1'b0, 1, 1'b0);
        wait_core_run();
        repeat (5) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrun_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("midrun_busy", 32'(busy), 32'd0);
        chk("midrun_ld_ready", 32'(ld_ready), 32'd0);
        chk("midrun_done", 32'(done), 32'd0);
        chk("midrun_cycle_cnt", cycle_cnt, 32'd0);
        exp_res.delete();
        exp_wr.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Recovery after the aborted run.
        begin_run(4, 1'b1, 0, 1'b1);
        finish_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
